// File: rtl/reg_file_sb_if.sv
// Register-file bus: write, reserve, init and dual read ports bundled for reg_file_sb.
// master drives addresses/strobes; slave returns read data, pending bits and init_busy.
interface reg_file_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              pend_a;
    logic              pend_b;
    logic              init_req;
    logic              init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr, init_req,
        input  rd_data_a, rd_data_b, pend_a, pend_b, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr, init_req,
        output rd_data_a, rd_data_b, pend_a, pend_b, init_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register bank, 1W/2R, pending scoreboard and NUM_REGS-cycle clear sweep; REG_FILE_ZERO_REG_EN hardwires r0.
// Reads are zero-latency (optional write bypass); no backpressure, strobes are dropped while init_busy.
module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1
) (
    input logic          clk,
    input logic          clr,
    reg_file_sb_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]  NREGS_X  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                init_busy_q, init_busy_d;

    logic              wr_en, rsv_en, init_req, wr_ok, rsv_ok;
    logic [ADDR_W-1:0] wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH:0]    rd_a, rd_b;

    assign wr_en     = bus.wr_en;
    assign wr_addr   = bus.wr_addr;
    assign wr_data   = bus.wr_data;
    assign rsv_en    = bus.rsv_en;
    assign rsv_addr  = bus.rsv_addr;
    assign init_req  = bus.init_req;
    assign rd_addr_a = bus.rd_addr_a;
    assign rd_addr_b = bus.rd_addr_b;

    // An address is usable only if it maps to a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_X) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_ok  = (state_q == IDLE) && wr_en  && addr_ok(wr_addr);
    assign rsv_ok = (state_q == IDLE) && rsv_en && addr_ok(rsv_addr);

    // Returns {pend, data}; wr_ok already implies IDLE, so no bypass during a sweep.
    function automatic logic [WIDTH:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH:0] r;
        r = '0;
        if (addr_ok(a)) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == a))
                r = {rsv_ok && (rsv_addr == a), wr_data};
            else
                r = {pend_q[a[IDX_W-1:0]], regs_q[a[IDX_W-1:0]]};
        end
        return r;
    endfunction

    assign rd_a = read_port(rd_addr_a);
    assign rd_b = read_port(rd_addr_b);

    assign bus.rd_data_a = rd_a[WIDTH-1:0];
    assign bus.pend_a    = rd_a[WIDTH];
    assign bus.rd_data_b = rd_b[WIDTH-1:0];
    assign bus.pend_b    = rd_b[WIDTH];
    assign bus.init_busy = init_busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    regs_d[wr_addr[IDX_W-1:0]] = wr_data;
                    pend_d[wr_addr[IDX_W-1:0]] = 1'b0;
                end
                // Reserve after write: a fresh producer owns the register.
                if (rsv_ok)
                    pend_d[rsv_addr[IDX_W-1:0]] = 1'b1;
                if (init_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                regs_d[cnt_q] = '0;
                pend_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        init_busy_d = (state_d == SWEEP);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            init_busy_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            init_busy_q <= init_busy_d;
            regs_q      <= regs_d;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table through a scoreboard queue, then sweep, abort and no-bypass sequences.
module tb_reg_file_sb;
    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 5;
`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    localparam logic [31:0] R0D = ZR ? 32'h0 : 32'hFFFF_FFFF;
    localparam logic        R0P = ZR ? 1'b0 : 1'b1;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    reg_file_sb_if #(.WIDTH(W), .ADDR_W(AW)) bus  ();
    reg_file_sb_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();

    reg_file_sb #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(AW), .BYPASS(1)) dut  (.clk(clk), .clr(clr), .bus(bus));
    reg_file_sb #(.WIDTH(W), .NUM_REGS(N), .ADDR_W(AW), .BYPASS(0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));

    typedef struct {
        logic we; logic [AW-1:0] wa; logic [31:0] wd;
        logic re; logic [AW-1:0] ra;
        logic [AW-1:0] aa, ab;
        logic [31:0] eda; logic epa; logic [31:0] edb; logic epb; logic ebusy;
    } vec_t;

    typedef struct {
        logic [31:0] da; logic pa; logic [31:0] db; logic pb; logic busy;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] mdl [N];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input int wa, input logic [31:0] wd,
                                input logic re, input int ra, input int aa, input int ab,
                                input logic [31:0] eda, input logic epa,
                                input logic [31:0] edb, input logic epb);
        vec_t v;
        v.we = we; v.wa = AW'(wa); v.wd = wd; v.re = re; v.ra = AW'(ra);
        v.aa = AW'(aa); v.ab = AW'(ab);
        v.eda = eda; v.epa = epa; v.edb = edb; v.epb = epb; v.ebusy = 1'b0;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rsv_en = 0; bus.rsv_addr = '0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.init_req = 0;
        bus0.wr_en = 0; bus0.wr_addr = '0; bus0.wr_data = '0; bus0.rsv_en = 0; bus0.rsv_addr = '0;
        bus0.rd_addr_a = '0; bus0.rd_addr_b = '0; bus0.init_req = 0;
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        bus.wr_en = v.we; bus.wr_addr = v.wa; bus.wr_data = v.wd;
        bus.rsv_en = v.re; bus.rsv_addr = v.ra;
        bus.rd_addr_a = v.aa; bus.rd_addr_b = v.ab; bus.init_req = 1'b0;
        e.da = v.eda; e.pa = v.epa; e.db = v.edb; e.pb = v.epb; e.busy = v.ebusy;
        sb.push_back(e);
    endtask

    task automatic compare(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            check({nm, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({nm, "_da"}, bus.rd_data_a, e.da);
            check({nm, "_pa"}, bus.pend_a, e.pa);
            check({nm, "_db"}, bus.rd_data_b, e.db);
            check({nm, "_pb"}, bus.pend_b, e.pb);
            check({nm, "_busy"}, bus.init_busy, e.busy);
        end
    endtask

    task automatic read_all_zero(input string nm);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            bus.rd_addr_a = AW'(i);
            bus.rd_addr_b = AW'(N - 1 - i);
            @(negedge clk);
            check($sformatf("%s_r%0d_dat", nm, i), bus.rd_data_a, 0);
            check($sformatf("%s_r%0d_pend", nm, i), bus.pend_b, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int busy_cnt;
        bit done;

        vt.push_back(mk(0,  0, 32'h0,         0,  0,  5,  6, 32'h0,         0, 32'h0,         0));
        vt.push_back(mk(1,  5, 32'hDEADBEEF,  0,  0,  5,  6, 32'hDEADBEEF,  0, 32'h0,         0));
        vt.push_back(mk(0,  0, 32'h0,         0,  0,  5,  6, 32'hDEADBEEF,  0, 32'h0,         0));
        vt.push_back(mk(1,  3, 32'h12345678,  0,  0,  3,  5, 32'h12345678,  0, 32'hDEADBEEF,  0));
        vt.push_back(mk(0,  0, 32'h0,         1,  7,  7,  3, 32'h0,         0, 32'h12345678,  0));
        vt.push_back(mk(0,  0, 32'h0,         0,  0,  7,  7, 32'h0,         1, 32'h0,         1));
        vt.push_back(mk(1,  7, 32'hA5,        0,  0,  7,  7, 32'hA5,        0, 32'hA5,        0));
        vt.push_back(mk(0,  0, 32'h0,         0,  0,  7,  7, 32'hA5,        0, 32'hA5,        0));
        vt.push_back(mk(1,  7, 32'h5A,        1,  7,  7,  7, 32'h5A,        1, 32'h5A,        1));
        vt.push_back(mk(0,  0, 32'h0,         0,  0,  7, 20, 32'h5A,        1, 32'h0,         0));
        vt.push_back(mk(1, 20, 32'hFFFFFFFF,  0,  0, 20,  5, 32'h0,         0, 32'hDEADBEEF,  0));
        vt.push_back(mk(0,  0, 32'h0,         1, 20, 20,  4, 32'h0,         0, 32'h0,         0));
        vt.push_back(mk(0,  0, 32'h0,         0,  0,  5,  7, 32'hDEADBEEF,  0, 32'h5A,        1));
        vt.push_back(mk(1,  0, 32'hFFFFFFFF,  1,  0,  0,  3, R0D,           R0P, 32'h12345678, 0));
        vt.push_back(mk(0,  0, 32'h0,         0,  0,  0, 16, R0D,           R0P, 32'h0,         0));

        idle_inputs();
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            drive(vt[i]);
            @(negedge clk);
            compare($sformatf("vec%0d", i));
        end
        check("sb_drained", sb.size(), 0);

        // Non-bypass instance: stored value until the edge after the write.
        idle_inputs();
        @(posedge clk); #1;
        bus0.rsv_en = 1; bus0.rsv_addr = 3;
        @(posedge clk); #1;
        bus0.rsv_en = 0;
        bus0.wr_en = 1; bus0.wr_addr = 3; bus0.wr_data = 32'h12345678; bus0.rd_addr_a = 3;
        @(negedge clk);
        check("nobyp_old_dat", bus0.rd_data_a, 0);
        check("nobyp_old_pend", bus0.pend_a, 1);
        @(posedge clk); #1;
        bus0.wr_en = 0;
        @(negedge clk);
        check("nobyp_new_dat", bus0.rd_data_a, 32'h12345678);
        check("nobyp_new_pend", bus0.pend_a, 0);

        // Fill, reserve r9, then sweep.
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = 32'h1000_0000 | i;
            mdl[i] = (ZR && i == 0) ? 32'h0 : (32'h1000_0000 | i);
        end
        @(posedge clk); #1;
        bus.wr_en = 0; bus.rsv_en = 1; bus.rsv_addr = 9;
        bus.rd_addr_a = 2; bus.rd_addr_b = 15;
        @(negedge clk);
        check("fill_r2", bus.rd_data_a, mdl[2]);
        check("fill_r15", bus.rd_data_b, mdl[15]);
        @(posedge clk); #1;
        bus.rsv_en = 0; bus.rd_addr_b = 9; bus.init_req = 1;
        @(negedge clk);
        check("pre_sweep_pend9", bus.pend_b, 1);
        check("pre_sweep_busy", bus.init_busy, 0);

        cyc = 0; busy_cnt = 0; done = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            bus.init_req  = (cyc == 8);
            bus.wr_en     = (cyc == 5);
            bus.wr_addr   = 2;
            bus.wr_data   = 32'hBAD0_BAD0;
            bus.rd_addr_a = 2;
            @(negedge clk);
            if (cyc == 5) check("sweep_no_bypass", bus.rd_data_a, 0);
            if (bus.init_busy) busy_cnt++;
            else done = 1;
            cyc++;
        end
        check("sweep_len", busy_cnt, N);
        idle_inputs();
        read_all_zero("post_sweep");

        // Write coincident with init_req, then abort the sweep with reset.
        @(posedge clk); #1;
        bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'h77; bus.init_req = 1; bus.rd_addr_a = 4;
        @(negedge clk);
        check("wr_init_bypass", bus.rd_data_a, 32'h77);
        @(posedge clk); #1;
        bus.wr_en = 0; bus.init_req = 0;
        @(negedge clk);
        check("wr_init_busy", bus.init_busy, 1);
        check("wr_before_sweep", bus.rd_data_a, 32'h77);
        repeat (4) @(posedge clk);
        #2 clr = 1'b0;
        #1;
        check("abort_busy", bus.init_busy, 0);
        check("abort_dat", bus.rd_data_a, 0);
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        check("abort_idle", bus.init_busy, 0);
        read_all_zero("post_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single 32-bit enable register: a multi-register bank with one write port and two read ports.
- Carries a per-register pending scoreboard for hazard detection and a sequenced bulk-clear engine.
- Replaces the individually instantiated general-purpose registers feeding the bus mux in the datapath.

Parameters:
- WIDTH, 32, data width of each register
- NUM_REGS, 16, number of registers; 2..256
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= NUM_REGS
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = no forwarding

Ports:
- clk  input  1  clock; all state updates on the rising edge
- clr  input  1  reset; asynchronous, active-low
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data
- rd_addr_a  input  ADDR_W  read port A address
- rd_data_a  output  WIDTH  read port A data (combinational)
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_b  output  WIDTH  read port B data (combinational)
- rsv_en  input  1  reserve strobe; marks a register as awaiting a result
- rsv_addr  input  ADDR_W  reserve address
- pend_a  output  1  pending bit of rd_addr_a
- pend_b  output  1  pending bit of rd_addr_b
- init_req  input  1  starts a sequenced clear of all registers
- init_busy  output  1  high while the clear sweep runs

Behaviour:
Reset (clr low, asynchronous):
- All registers are cleared to 0.
- All pending bits are cleared to 0.
- The FSM goes to IDLE; the sweep counter is cleared to 0; init_busy = 0.
- If reset is asserted mid-sweep, the sweep aborts immediately and the FSM returns to IDLE.

Write:
- In IDLE, on a rising edge with wr_en = 1 and wr_addr < NUM_REGS: reg[wr_addr] <= wr_data and pend[wr_addr] <= 0.
- wr_addr >= NUM_REGS: the write is ignored and no state changes.

Reserve:
- In IDLE, with rsv_en = 1 and rsv_addr < NUM_REGS: pend[rsv_addr] <= 1.
- Reserve and write to the same address in the same cycle: the data is written and the pending bit ends at 1 (reserve wins; a new producer is issued).
- rsv_addr out of range: ignored.

Read:
- Combinational; zero latency.
- rd_addr >= NUM_REGS: data and pend return 0.
- BYPASS = 1, and wr_en = 1 with wr_addr == rd_addr and the FSM in IDLE: rd_data = wr_data and pend = 0 (or 1 if the same address is also reserved this cycle).
- BYPASS = 0: the read returns the stored value; the new data is visible the cycle after the write.
- Both ports are independent; identical addresses are legal.

FSM (states IDLE, SWEEP):
- IDLE -> SWEEP when init_req = 1; the counter loads 0.
- In SWEEP, each cycle: reg[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt + 1.
- SWEEP -> IDLE on the cycle that clears reg[NUM_REGS-1]; the sweep takes exactly NUM_REGS cycles.
- init_busy = 1 in SWEEP.
- In SWEEP, wr_en, rsv_en and init_req are ignored, and the read ports return stored contents with no bypass.
- init_req held high on the cycle the FSM returns to IDLE: a new sweep starts on the following edge; it is level-sensitive in IDLE.
- Write and init_req in the same IDLE cycle: the write completes that edge, then the sweep begins next cycle and clears it.

Optional Feature:
Macro REG_FILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to 0.
  - Writes and reserves to address 0 are discarded.
  - Reads of address 0 return 0 with pend = 0, including under bypass.
  - The sweep still runs NUM_REGS cycles.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then write 0xDEADBEEF to r5; next cycle read A=5 -> rd_data_a = 0xDEADBEEF, pend_a = 0; read B=6 -> 0.
- BYPASS=1: wr_en with r3 = 0x12345678 and rd_addr_a = 3 in the same cycle -> rd_data_a = 0x12345678 combinationally. BYPASS=0: the old value that cycle, 0x12345678 the next cycle.
- Reserve r7 -> pend = 1. Write r7 = 0xA5 -> pend = 0. Simultaneous reserve+write r7 = 0x5A -> data 0x5A, pend = 1.
- Fill all 16 registers, pulse init_req -> init_busy = 1 for exactly 16 cycles, with a write to r2 during the sweep ignored. Afterwards all reads = 0 and all pend = 0.
- Start a sweep, assert clr low at sweep cycle 4 -> init_busy drops asynchronously and all registers read 0 after reset release.
- REG_FILE_ZERO_REG_EN defined: write 0xFFFFFFFF to r0 and reserve r0 -> rd_data = 0, pend = 0. Write to address 20 (NUM_REGS = 16) -> no register changes.
